stump_control_ws: RTL

Parametrised Stump control unit with memory wait-state handshake, bus-timeout fault detection and a retired-instruction counter. Sequences FETCH → EXECUTE → (MEMORY) → FETCH, decodes the 16-bit Stump instruction into datapath controls, and stalls in FETCH/MEMORY until the memory system signals `mem_ready`. Sits between the Stump datapath (register bank, ALU, shifter, cc register, IR) and the memory interface, replacing the fixed-timing control block.

---
 rtl/stump_control_ws.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/stump_control_ws.sv
// Stump control unit: FETCH/EXECUTE/MEMORY sequencing with memory wait states,
// bus-timeout fault trapping and a wrapping retired-instruction counter.
module stump_control_ws #(
    parameter int PC_REG  = 7,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       cc,
    input  logic [15:0]      ir,
    input  logic             mem_ready,
    output logic             fetch,
    output logic             execute,
    output logic             memory,
    output logic             fault,
    output logic             ir_load,
    output logic             ext_op,
    output logic             reg_write,
    output logic [2:0]       dest,
    output logic [2:0]       srcA,
    output logic [2:0]       srcB,
    output logic [1:0]       shift_op,
    output logic             opB_mux_sel,
    output logic [2:0]       alu_func,
    output logic             cc_en,
    output logic             mem_ren,
    output logic             mem_wen,
    output logic             bus_error,
    output logic             retired,
    output logic [CNT_W-1:0] retire_count
);

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_EXECUTE = 2'd1;
    localparam logic [1:0] ST_MEMORY  = 2'd2;
    localparam logic [1:0] ST_FAULT   = 2'd3;

    localparam int         WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [2:0] PC_IDX = 3'(PC_REG);

    logic [1:0]        state_r;
    logic [1:0]        next_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              timeout_s;

    logic [2:0] op_s;
    logic       type_s;
    logic       is_ldst_s;
    logic       is_bcc_s;

    assign op_s      = ir[15:13];
    assign type_s    = ir[12];
    assign is_ldst_s = (op_s == 3'b110);
    assign is_bcc_s  = (op_s == 3'b111);

    // Branch condition evaluation; flags are {N,Z,V,C}.
    function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, v, c;
        n = flags[3];
        z = flags[2];
        v = flags[1];
        c = flags[0];
        case (cond)
            4'd0:    cond_true = 1'b1;
            4'd1:    cond_true = 1'b0;
            4'd2:    cond_true = !c && !z;
            4'd3:    cond_true = c || z;
            4'd4:    cond_true = !c;
            4'd5:    cond_true = c;
            4'd6:    cond_true = !z;
            4'd7:    cond_true = z;
            4'd8:    cond_true = !v;
            4'd9:    cond_true = v;
            4'd10:   cond_true = !n;
            4'd11:   cond_true = n;
            4'd12:   cond_true = (n == v);
            4'd13:   cond_true = (n != v);
            4'd14:   cond_true = !z && (n == v);
            4'd15:   cond_true = z || (n != v);
            default: cond_true = 1'b0;
        endcase
    endfunction

    // Timeout fires on the TIMEOUT-th consecutive not-ready cycle; ready always wins.
    always_comb begin
        timeout_s = 1'b0;
        if ((TIMEOUT != 0) && !mem_ready &&
            ((state_r == ST_FETCH) || (state_r == ST_MEMORY)) &&
            (int'(wait_cnt_r) == TIMEOUT - 1)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Next-state selection.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (mem_ready)      next_s = ST_EXECUTE;
                else if (timeout_s) next_s = ST_FAULT;
                else                next_s = ST_FETCH;
            end
            ST_EXECUTE: begin
                if (is_ldst_s) next_s = ST_MEMORY;
                else           next_s = ST_FETCH;
            end
            ST_MEMORY: begin
                if (mem_ready)      next_s = ST_FETCH;
                else if (timeout_s) next_s = ST_FAULT;
                else                next_s = ST_MEMORY;
            end
            ST_FAULT: next_s = ST_FAULT;
            default:  next_s = ST_FETCH;
        endcase
    end

    // Datapath control decode for the current state.
    always_comb begin
        fetch       = 1'b0;
        execute     = 1'b0;
        memory      = 1'b0;
        fault       = 1'b0;
        ir_load     = 1'b0;
        ext_op      = 1'b0;
        reg_write   = 1'b0;
        dest        = 3'd0;
        srcA        = 3'd0;
        srcB        = 3'd0;
        shift_op    = 2'd0;
        opB_mux_sel = 1'b0;
        alu_func    = 3'd0;
        cc_en       = 1'b0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        bus_error   = 1'b0;
        retired     = 1'b0;
        case (state_r)
            ST_FETCH: begin
                fetch   = 1'b1;
                mem_ren = 1'b1;
                ir_load = mem_ready;
            end
            ST_EXECUTE: begin
                execute = 1'b1;
                if (is_bcc_s) begin
                    srcA        = PC_IDX;
                    dest        = PC_IDX;
                    opB_mux_sel = 1'b1;
                    ext_op      = 1'b1;
                    reg_write   = cond_true(ir[11:8], cc);
                    retired     = 1'b1;
                end else begin
                    srcA        = ir[7:5];
                    opB_mux_sel = type_s;
                    if (!type_s) begin
                        srcB     = ir[4:2];
                        shift_op = ir[1:0];
                    end else begin
                        srcB     = 3'd0;
                        shift_op = 2'd0;
                    end
                    if (is_ldst_s) begin
                        alu_func = 3'b000;
                    end else begin
                        alu_func  = op_s;
                        reg_write = 1'b1;
                        dest      = ir[10:8];
                        cc_en     = ir[11];
                        retired   = 1'b1;
                    end
                end
            end
            ST_MEMORY: begin
                memory  = 1'b1;
                retired = mem_ready;
                if (!ir[11]) begin
                    mem_ren   = 1'b1;
                    dest      = ir[10:8];
                    reg_write = mem_ready;
                end else begin
                    mem_wen = 1'b1;
                    srcA    = ir[10:8];
                end
            end
            ST_FAULT: begin
                fault     = 1'b1;
                bus_error = 1'b1;
            end
            default: begin
                fetch = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_r <= ST_FETCH;
        else      state_r <= next_s;
    end

    // Wait counter: restarts on any state change or completed transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_r <= '0;
        end else if ((next_s != state_r) || mem_ready) begin
            wait_cnt_r <= '0;
        end else if ((state_r == ST_FETCH) || (state_r == ST_MEMORY)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= '0;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst)         retire_count <= '0;
        else if (retired) retire_count <= retire_count + CNT_W'(1);
        else              retire_count <= retire_count;
    end

endmodule
